// File: rtl/disp_pkg.sv
// Shared types and constants for the display source selector.
// Field-select codes, debounce state encoding and the display bundle width.
package disp_pkg;

  localparam int BUNDLE_W = 160;

  localparam logic [1:0] UPPER_F0 = 2'd0;
  localparam logic [1:0] UPPER_F1 = 2'd1;
  localparam logic [1:0] UPPER_F2 = 2'd2;
  localparam logic [1:0] UPPER_F3 = 2'd3;

  localparam logic [1:0] LOWER_W64   = 2'd0;
  localparam logic [1:0] LOWER_W96   = 2'd1;
  localparam logic [1:0] LOWER_W128  = 2'd2;
  localparam logic [1:0] LOWER_BLANK = 2'd3;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

endpackage

// File: rtl/disp_source_sel_if.sv
// Snapshot data path between the debug source, this block and the display driver.
// master = source/driver side, slave = disp_source_sel.
interface disp_source_sel_if;
  import disp_pkg::*;

  logic [BUNDLE_W-1:0] src_data;
  logic                src_valid;
  logic [BUNDLE_W-1:0] disp_reg;
  logic [3:0]          disp_ctrl;
  logic                snap_tick;

  modport master (
    output src_data, src_valid,
    input  disp_reg, disp_ctrl, snap_tick
  );

  modport slave (
    input  src_data, src_valid,
    output disp_reg, disp_ctrl, snap_tick
  );
endinterface

// File: rtl/btn_debounce.sv
// Synchroniser plus debounce FSM for one raw pushbutton; emits a one-cycle press pulse.
// Pulse is registered SYNC_STAGES+DEB_CYCLES edges after the raw level is first sampled high.
module btn_debounce
  import disp_pkg::*;
#(
  parameter int DEB_CYCLES  = 500000,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   level_in;
  deb_state_e             state;
  logic [CW-1:0]          cnt;

  assign level_in = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
    end
  end

  // cnt holds the number of consecutive samples already seen at the new level,
  // so the sample that leaves RELEASED/PRESSED is counted as the first one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RELEASED;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      case (state)
        RELEASED: begin
          if (level_in) begin
            if (DEB_CYCLES == 1) begin
              state <= PRESSED;
              press <= 1'b1;
            end else begin
              state <= PRESS_WAIT;
              cnt   <= CW'(1);
            end
          end
        end
        PRESS_WAIT: begin
          if (!level_in) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
            press <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (!level_in) begin
            if (DEB_CYCLES == 1) begin
              state <= RELEASED;
            end else begin
              state <= RELEASE_WAIT;
              cnt   <= CW'(1);
            end
          end
        end
        RELEASE_WAIT: begin
          if (level_in) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= RELEASED;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/disp_source_sel.sv
// Display source selector: snapshots debug data on src_valid unless frozen, steps field selects on debounced presses.
// disp_reg/snap_tick update on the edge after src_valid; optional auto-scroll of the lower field under DISP_AUTOSCROLL_EN.
module disp_source_sel
  import disp_pkg::*;
#(
  parameter int DEB_CYCLES    = 500000,
  parameter int SYNC_STAGES   = 2,
  parameter int SCROLL_CYCLES = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_hi,
  input  logic btn_lo,
  input  logic freeze_sw,
  disp_source_sel_if.slave bus
);

  if (DEB_CYCLES < 1 || SYNC_STAGES < 2 || SCROLL_CYCLES < 1) begin : g_bad_params
    $error("disp_source_sel: DEB_CYCLES>=1, SYNC_STAGES>=2, SCROLL_CYCLES>=1 required");
  end

  logic                   hi_press;
  logic                   lo_press;
  logic                   lo_step;
  logic [SYNC_STAGES-1:0] frz_sync;
  logic                   frozen;
  logic                   load;
  logic [BUNDLE_W-1:0]    disp_reg_q;
  logic [3:0]             disp_ctrl_q;
  logic                   snap_tick_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_hi),
    .press (hi_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_deb_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn_lo),
    .press (lo_press)
  );

  // The freeze switch is a level, so synchronising it is enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frz_sync <= '0;
    end else begin
      frz_sync <= {frz_sync[SYNC_STAGES-2:0], freeze_sw};
    end
  end

  assign frozen = frz_sync[SYNC_STAGES-1];
  assign load   = bus.src_valid && !frozen;

`ifdef DISP_AUTOSCROLL_EN
  localparam int SW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_CYCLES - 1);

  logic [SW-1:0] scroll_cnt;
  logic          scroll_wrap;

  assign scroll_wrap = !frozen && (scroll_cnt == SCROLL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scroll_cnt <= '0;
    end else if (lo_press) begin
      scroll_cnt <= '0;
    end else if (!frozen) begin
      scroll_cnt <= (scroll_cnt == SCROLL_LAST) ? '0 : scroll_cnt + SW'(1);
    end
  end

  // A wrap landing on a manual press still advances the field only once.
  assign lo_step = lo_press || scroll_wrap;
`else
  assign lo_step = lo_press;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_reg_q  <= '0;
      disp_ctrl_q <= {UPPER_F0, LOWER_W64};
      snap_tick_q <= 1'b0;
    end else begin
      snap_tick_q <= load;
      if (load) begin
        disp_reg_q <= bus.src_data;
      end
      if (hi_press) begin
        disp_ctrl_q[3:2] <= disp_ctrl_q[3:2] + 2'd1;
      end
      if (lo_step) begin
        disp_ctrl_q[1:0] <= disp_ctrl_q[1:0] + 2'd1;
      end
    end
  end

  assign bus.disp_reg  = disp_reg_q;
  assign bus.disp_ctrl = disp_ctrl_q;
  assign bus.snap_tick = snap_tick_q;

endmodule

// File: tb/tb_disp_source_sel.sv
// Bench for disp_source_sel with DEB_CYCLES=4, SYNC_STAGES=2 (auto-scroll disabled).
// Directed scenarios plus randomized traffic against a run-length reference model.
module tb_disp_source_sel;
  import disp_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_hi = 1'b0;
  logic btn_lo = 1'b0;
  logic freeze_sw = 1'b0;

  int total = 0;
  int bad = 0;

  disp_source_sel_if bus();

  disp_source_sel #(.DEB_CYCLES(N), .SYNC_STAGES(2), .SCROLL_CYCLES(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_hi    (btn_hi),
    .btn_lo    (btn_lo),
    .freeze_sw (freeze_sw),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // Reference model: each input is seen two edges late; a button level is accepted once
  // N consecutive seen samples differ from the accepted level; a new press bumps its field one edge later.
  logic                h_d1, h_d2, l_d1, l_d2, f_d1, f_d2;
  logic                lvl_h, lvl_l, pend_h, pend_l;
  int                  run_h, run_l;
  logic [3:0]          exp_ctrl;
  logic [BUNDLE_W-1:0] exp_reg;
  logic                exp_tick;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_d1 <= 0; h_d2 <= 0; l_d1 <= 0; l_d2 <= 0; f_d1 <= 0; f_d2 <= 0;
      lvl_h <= 0; lvl_l <= 0; pend_h <= 0; pend_l <= 0; run_h <= 0; run_l <= 0;
      exp_ctrl <= 4'b0000; exp_reg <= '0; exp_tick <= 0;
    end else begin
      h_d1 <= btn_hi; h_d2 <= h_d1;
      l_d1 <= btn_lo; l_d2 <= l_d1;
      f_d1 <= freeze_sw; f_d2 <= f_d1;
      if (h_d2 != lvl_h) begin
        if (run_h + 1 == N) begin lvl_h <= h_d2; run_h <= 0; end
        else run_h <= run_h + 1;
      end else run_h <= 0;
      if (l_d2 != lvl_l) begin
        if (run_l + 1 == N) begin lvl_l <= l_d2; run_l <= 0; end
        else run_l <= run_l + 1;
      end else run_l <= 0;
      pend_h <= (h_d2 != lvl_h) && (run_h + 1 == N) && h_d2;
      pend_l <= (l_d2 != lvl_l) && (run_l + 1 == N) && l_d2;
      exp_ctrl <= {exp_ctrl[3:2] + {1'b0, pend_h}, exp_ctrl[1:0] + {1'b0, pend_l}};
      exp_tick <= bus.src_valid && !f_d2;
      if (bus.src_valid && !f_d2) exp_reg <= bus.src_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit hi, input bit lo);
    if (hi) btn_hi = 1'b1;
    if (lo) btn_lo = 1'b1;
    repeat (6) step();
    btn_hi = 1'b0;
    btn_lo = 1'b0;
    repeat (8) step();
  endtask

  function automatic logic [BUNDLE_W-1:0] rand_bundle();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data = '0;
    step();
    total++; if (bus.disp_reg !== '0) begin bad++; $display("FAIL reset_reg got=%h want=0", bus.disp_reg); end
    total++; if (bus.disp_ctrl !== 4'b0000) begin bad++; $display("FAIL reset_ctrl got=%b want=0000", bus.disp_ctrl); end
    total++; if (bus.snap_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", bus.snap_tick); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_snapshot();
    logic [BUNDLE_W-1:0] k;
    k = 160'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978_8796_CAFE;
    bus.src_data = k;
    bus.src_valid = 1'b1;
    step();
    bus.src_valid = 1'b0;
    bus.src_data = rand_bundle();
    total++; if (bus.disp_reg !== k) begin bad++; $display("FAIL snap_reg got=%h want=%h", bus.disp_reg, k); end
    total++; if (bus.snap_tick !== 1'b1) begin bad++; $display("FAIL snap_tick_hi got=%b want=1", bus.snap_tick); end
    step();
    total++; if (bus.snap_tick !== 1'b0) begin bad++; $display("FAIL snap_tick_lo got=%b want=0", bus.snap_tick); end
    total++; if (bus.disp_reg !== k) begin bad++; $display("FAIL snap_hold got=%h want=%h", bus.disp_reg, k); end
    for (int i = 0; i < 6; i++) begin
      k = rand_bundle();
      bus.src_data = k;
      bus.src_valid = 1'b1;
      step();
      bus.src_valid = 1'b0;
      total++; if (bus.disp_reg !== k || bus.snap_tick !== 1'b1) begin
        bad++; $display("FAIL snap_rand i=%0d got=%h tick=%b want=%h tick=1", i, bus.disp_reg, bus.snap_tick, k);
      end
    end
    step();
  endtask

  task automatic test_btn_lo_latency();
    btn_lo = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      total++;
      if (bus.disp_ctrl !== ((e < 7) ? 4'b0000 : 4'b0001)) begin
        bad++; $display("FAIL lo_latency edge=%0d got=%b want=%b", e, bus.disp_ctrl, (e < 7) ? 4'b0000 : 4'b0001);
      end
    end
    repeat (3) step();
    btn_lo = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step();
      total++; if (bus.disp_ctrl !== 4'b0001) begin bad++; $display("FAIL lo_release edge=%0d got=%b want=0001", e, bus.disp_ctrl); end
    end
  endtask

  task automatic test_bounce();
    logic [6:0] pat;
    logic [1:0] want_hi;
    pat = 7'b1101110;
    for (int i = 6; i >= 0; i--) begin
      btn_hi = pat[i];
      step();
    end
    btn_hi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      total++; if (bus.disp_ctrl !== 4'b0001) begin bad++; $display("FAIL bounce cyc=%0d got=%b want=0001", i, bus.disp_ctrl); end
    end
    want_hi = 2'd0;
    for (int p = 0; p < 4; p++) begin
      press(1'b1, 1'b0);
      want_hi = want_hi + 2'd1;
      total++; if (bus.disp_ctrl !== {want_hi, 2'b01}) begin
        bad++; $display("FAIL clean_press p=%0d got=%b want=%b", p, bus.disp_ctrl, {want_hi, 2'b01});
      end
    end
  endtask

  task automatic test_freeze();
    logic [BUNDLE_W-1:0] old_v, new_v;
    old_v = bus.disp_reg;
    new_v = rand_bundle();
    freeze_sw = 1'b1;
    repeat (3) step();
    bus.src_data = new_v;
    bus.src_valid = 1'b1;
    step();
    bus.src_valid = 1'b0;
    total++; if (bus.disp_reg !== old_v) begin bad++; $display("FAIL freeze_hold got=%h want=%h", bus.disp_reg, old_v); end
    total++; if (bus.snap_tick !== 1'b0) begin bad++; $display("FAIL freeze_tick got=%b want=0", bus.snap_tick); end
    press(1'b0, 1'b1);
    total++; if (bus.disp_ctrl !== 4'b0010) begin bad++; $display("FAIL freeze_btn got=%b want=0010", bus.disp_ctrl); end
    total++; if (bus.disp_reg !== old_v) begin bad++; $display("FAIL freeze_hold2 got=%h want=%h", bus.disp_reg, old_v); end
    freeze_sw = 1'b0;
    repeat (3) step();
    bus.src_valid = 1'b1;
    step();
    bus.src_valid = 1'b0;
    total++; if (bus.disp_reg !== new_v || bus.snap_tick !== 1'b1) begin
      bad++; $display("FAIL unfreeze got=%h tick=%b want=%h tick=1", bus.disp_reg, bus.snap_tick, new_v);
    end
  endtask

  task automatic test_simultaneous();
    press(1'b0, 1'b1);
    repeat (3) press(1'b1, 1'b0);
    total++; if (bus.disp_ctrl !== 4'b1111) begin bad++; $display("FAIL simul_setup got=%b want=1111", bus.disp_ctrl); end
    btn_hi = 1'b1;
    btn_lo = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step();
      total++;
      if (bus.disp_ctrl !== ((e < 7) ? 4'b1111 : 4'b0000)) begin
        bad++; $display("FAIL simul_wrap edge=%0d got=%b want=%b", e, bus.disp_ctrl, (e < 7) ? 4'b1111 : 4'b0000);
      end
    end
    btn_hi = 1'b0;
    btn_lo = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_reset_mid_press();
    int changes;
    logic [3:0] prev;
    btn_lo = 1'b1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    total++; if (bus.disp_reg !== '0 || bus.disp_ctrl !== 4'b0000 || bus.snap_tick !== 1'b0) begin
      bad++; $display("FAIL midrst_clear reg=%h ctrl=%b tick=%b want all 0", bus.disp_reg, bus.disp_ctrl, bus.snap_tick);
    end
    repeat (2) step();
    rst_n = 1'b1;
    changes = 0;
    prev = bus.disp_ctrl;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (e == 12) btn_lo = 1'b0;
      if (bus.disp_ctrl !== prev) changes++;
      prev = bus.disp_ctrl;
      if (e == 6 || e == 7) begin
        total++;
        if (bus.disp_ctrl !== ((e == 6) ? 4'b0000 : 4'b0001)) begin
          bad++; $display("FAIL midrst_latency edge=%0d got=%b want=%b", e, bus.disp_ctrl, (e == 6) ? 4'b0000 : 4'b0001);
        end
      end
    end
    total++; if (bus.disp_ctrl !== 4'b0001 || changes != 1) begin
      bad++; $display("FAIL midrst_once got=%b changes=%0d want=0001 changes=1", bus.disp_ctrl, changes);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) btn_hi = ~btn_hi;
      if ($urandom_range(0, 5) == 0) btn_lo = ~btn_lo;
      if ($urandom_range(0, 24) == 0) freeze_sw = ~freeze_sw;
      bus.src_valid = ($urandom_range(0, 2) == 0);
      bus.src_data = rand_bundle();
      step();
      total++; if (bus.disp_ctrl !== exp_ctrl) begin bad++; $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", c, bus.disp_ctrl, exp_ctrl); end
      total++; if (bus.disp_reg !== exp_reg) begin bad++; $display("FAIL rand_reg cyc=%0d got=%h want=%h", c, bus.disp_reg, exp_reg); end
      total++; if (bus.snap_tick !== exp_tick) begin bad++; $display("FAIL rand_tick cyc=%0d got=%b want=%b", c, bus.snap_tick, exp_tick); end
    end
    bus.src_valid = 1'b0;
    btn_hi = 1'b0;
    btn_lo = 1'b0;
    freeze_sw = 1'b0;
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_btn_lo_latency();
    test_bounce();
    test_freeze();
    test_simultaneous();
    test_reset_mid_press();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
